message_sequencer: RTL and testbench
====================================

# message_sequencer

Frame-synchronous page controller that sits beside `vga_driver` in the 25 MHz pixel-clock domain. Debounces the push button, tracks which message page is displayed, and sequences page changes as fade-out / switch / fade-in transitions via a 4-bit brightness level. All visible changes (page, brightness) occur only at vertical-sync boundaries, so a frame never shows a mid-frame change. Auto-advances pages after a programmable hold time.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable clk cycles required to accept a new button level (10 ms at 25 MHz).
- `NUM_PAGES`, 4: number of message pages, range 2..8.
- `HOLD_FRAMES`, 300: frames a page is held at full brightness before auto-advance; 0 disables auto-advance.
- `FADE_STEP_FRAMES`, 4: frames per brightness step during a fade, minimum 1.
- `clk`  in  1  25 MHz pixel clock.
- `reset`  in  1  synchronous, active-high reset.
- `button`  in  1  raw asynchronous push button, active high.
- `vs`  in  1  vertical sync from `vga_driver`, active low, same clock domain.
- `page`  out  3  current page index, 0..NUM_PAGES-1.
- `brightness`  out  4  display intensity, 0 = black, 15 = full.
- `frame_tick`  out  1  one-cycle pulse per frame.
- `busy`  out  1  high while a transition is in progress (any state other than SHOW).

## Operation
- Button path: 2-flop synchronizer, then debounce counter. The counter resets whenever the synchronized level equals the debounced level. The debounced level flips when the counter reaches DEBOUNCE_CYCLES-1 with the level still differing. A rising edge of the debounced level produces one internal `press` pulse.
- Pending press: a single flag, set by `press` and cleared when consumed. Extra presses while the flag is set are dropped (no queueing beyond one).
- Frame tick: `vs` is registered once. `frame_tick` is a registered pulse asserted the cycle after `vs` is first sampled low following a high sample.
- FSM states: SHOW, FADE_OUT, SWITCH, FADE_IN. Every transition except SWITCH -> FADE_IN is evaluated only on `frame_tick`.
  - SHOW, brightness 15, hold counter increments per tick:
    - pending set -> clear pending, go to FADE_OUT, hold counter cleared.
    - otherwise, HOLD_FRAMES != 0 and hold counter reaches HOLD_FRAMES-1 -> go to FADE_OUT.
    - pending has priority if both are true on the same tick.
  - FADE_OUT: a step counter counts ticks; every FADE_STEP_FRAMES ticks, brightness decrements by 1. The tick that would decrement from 0 instead moves to SWITCH.
  - SWITCH, one cycle: page <= (page == NUM_PAGES-1) ? 0 : page+1, then go to FADE_IN.
  - FADE_IN: brightness increments by 1 every FADE_STEP_FRAMES ticks. The step that reaches 15 also enters SHOW, with hold counter 0.
- Presses during FADE_OUT / SWITCH / FADE_IN set pending. Pending is serviced on the first tick after returning to SHOW.
- Brightness saturates at 0 and 15; no wrap. Page wraps NUM_PAGES-1 -> 0.

## Timing
- Reset values:
  - page=0, brightness=15, busy=0, frame_tick=0, state SHOW.
  - debounced level 0, pending 0, all counters 0, `vs` register 1.
- Reset mid-fade: returns immediately to the reset values on the next edge; the pending press is discarded.
- Button latency: raw edge -> internal `press` is 2 + DEBOUNCE_CYCLES cycles. Any glitch shorter than DEBOUNCE_CYCLES produces no press.
- `frame_tick` latency: 1 cycle after the first low sample of `vs`. A `vs` held low produces exactly one tick.
- `busy` is registered with the state and rises in the cycle SHOW -> FADE_OUT takes effect.
- Full transition length is 16*FADE_STEP_FRAMES ticks for the fade out (15 decrements plus the exit tick), plus 1 SWITCH cycle, plus 15*FADE_STEP_FRAMES ticks for the fade in.
- A press and `frame_tick` in the same cycle: pending is set that cycle and evaluated on the next tick.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, NUM_PAGES=3, HOLD_FRAMES=3, FADE_STEP_FRAMES=1. `vs` is driven low for 2 cycles every 20 cycles.
- Reset: assert `reset` for 2 cycles -> page=0, brightness=15, busy=0, frame_tick=0.
- Debounce: `button` high for 3 cycles, then low -> no transition. `button` high for 10 cycles -> busy rises on the next frame_tick, then brightness steps 15,14,...,0 on successive ticks.
- Auto-advance with the button idle:
  - after 3 ticks in SHOW -> fade out, SWITCH, then page=1 and brightness steps 0..15.
  - repeating to page 2 and then page 0 confirms the wrap.
- Press during fade: press while brightness=8 in FADE_OUT -> page advances once. After SHOW is re-entered, the next tick starts a second FADE_OUT. Two presses during the fade still yield only one extra advance.
- Reset mid-transition: assert `reset` while brightness=5 in FADE_IN -> the next cycle shows page=0, brightness=15, busy=0, and no residual pending press.
- `vs` held low for 100 cycles -> exactly one frame_tick pulse.

Source files
------------

// File: rtl/message_sequencer.sv
// message_sequencer
// Frame-synchronous page controller running in the pixel-clock domain.
// It debounces the push button and tracks the displayed message page.
// Page changes are sequenced as fade-out, page switch, then fade-in.
// Page and brightness only change on frame ticks, so a change never lands mid-frame.
// Pages auto-advance after a programmable hold time.
//
// Ports:
//   clk        in   pixel clock
//   reset      in   synchronous, active-high reset
//   button     in   raw push button, active high (asynchronous)
//   vs         in   vertical sync, active low, same clock domain
//   page       out  current page index, 0..NUM_PAGES-1
//   brightness out  display intensity, 0 = black, 15 = full
//   frame_tick out  one-cycle pulse per frame
//   busy       out  high while a transition is in progress
//
// States:
//   SHOW     | page displayed at full brightness, hold counter running
//   FADE_OUT | brightness stepping down toward 0
//   SWITCH   | single cycle, page advances
//   FADE_IN  | brightness stepping up toward 15
module message_sequencer #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int NUM_PAGES        = 4,
  parameter int HOLD_FRAMES      = 300,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       vs,
  output logic [2:0] page,
  output logic [3:0] brightness,
  output logic       frame_tick,
  output logic       busy
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HLW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int STW = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HLW-1:0] HOLD_LAST = HLW'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
  localparam logic [STW-1:0] STEP_LAST = STW'(FADE_STEP_FRAMES - 1);
  localparam logic [2:0]     PAGE_LAST = 3'(NUM_PAGES - 1);

  typedef enum logic [1:0] {SHOW, FADE_OUT, SWITCH, FADE_IN} state_t;

  state_t           state, state_n;
  logic [2:0]       page_n;
  logic [3:0]       brightness_n;
  logic [HLW-1:0]   hold_cnt, hold_cnt_n;
  logic [STW-1:0]   step_cnt, step_cnt_n;
  logic             pending, pending_n;
  logic             consume;

  logic             btn_meta, btn_sync;
  logic             db_level, db_prev;
  logic [DBW-1:0]   db_cnt;
  logic             vs_q;
  logic             press;

  // Button synchronizer, debounce and frame tick detection
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      db_level   <= 1'b0;
      db_prev    <= 1'b0;
      db_cnt     <= '0;
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      db_prev  <= db_level;
      // Any sample agreeing with the accepted level restarts the stability window
      if (btn_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_sync;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      vs_q       <= vs;
      frame_tick <= vs_q & ~vs;
    end
  end

  assign press = db_level & ~db_prev;
  assign busy  = (state != SHOW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHOW;
      page       <= 3'd0;
      brightness <= 4'd15;
      hold_cnt   <= '0;
      step_cnt   <= '0;
      pending    <= 1'b0;
    end else begin
      state      <= state_n;
      page       <= page_n;
      brightness <= brightness_n;
      hold_cnt   <= hold_cnt_n;
      step_cnt   <= step_cnt_n;
      pending    <= pending_n;
    end
  end

  always_comb begin
    state_n      = state;
    page_n       = page;
    brightness_n = brightness;
    hold_cnt_n   = hold_cnt;
    step_cnt_n   = step_cnt;
    consume      = 1'b0;
    case (state)
      SHOW: begin
        if (frame_tick) begin
          if (pending) begin
            consume    = 1'b1;
            state_n    = FADE_OUT;
            hold_cnt_n = '0;
            step_cnt_n = '0;
          end else if ((HOLD_FRAMES != 0) && (hold_cnt == HOLD_LAST)) begin
            state_n    = FADE_OUT;
            hold_cnt_n = '0;
            step_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_cnt + 1'b1;
          end
        end
      end
      FADE_OUT: begin
        if (frame_tick) begin
          if (step_cnt == STEP_LAST) begin
            step_cnt_n = '0;
            // The step that would go below 0 ends the fade instead
            if (brightness == 4'd0) state_n = SWITCH;
            else brightness_n = brightness - 4'd1;
          end else begin
            step_cnt_n = step_cnt + 1'b1;
          end
        end
      end
      SWITCH: begin
        page_n     = (page == PAGE_LAST) ? 3'd0 : page + 3'd1;
        step_cnt_n = '0;
        state_n    = FADE_IN;
      end
      FADE_IN: begin
        if (frame_tick) begin
          if (step_cnt == STEP_LAST) begin
            step_cnt_n = '0;
            if (brightness != 4'd15) brightness_n = brightness + 4'd1;
            if (brightness >= 4'd14) begin
              state_n    = SHOW;
              hold_cnt_n = '0;
            end
          end else begin
            step_cnt_n = step_cnt + 1'b1;
          end
        end
      end
      default: state_n = SHOW;
    endcase
    // A press arriving in the same cycle as a consume becomes the new pending press
    pending_n = (pending & ~consume) | press;
  end

endmodule

// File: tb/tb_message_sequencer.sv
// Testbench for message_sequencer.
// A frame-level reference model pushes the expected page, brightness and busy values into a scoreboard queue.
// The values are predicted for the cycle after each frame tick.
// A monitor process pops an entry on every frame_tick and compares it with the DUT outputs.
module tb_message_sequencer;

  localparam int DB    = 4;
  localparam int NP    = 3;
  localparam int HOLD  = 3;
  localparam int STEP  = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic       vs = 1'b1;
  logic [2:0] page;
  logic [3:0] brightness;
  logic       frame_tick;
  logic       busy;

  always #5 clk = ~clk;

  message_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .NUM_PAGES       (NP),
    .HOLD_FRAMES     (HOLD),
    .FADE_STEP_FRAMES(STEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .vs        (vs),
    .page      (page),
    .brightness(brightness),
    .frame_tick(frame_tick),
    .busy      (busy)
  );

  // phase: 0 showing, 1 fading out, 2 switching, 3 fading in
  typedef struct {
    int page;
    int bright;
    int busy;
    int phase;
  } rec_t;

  rec_t sched[$];
  rec_t sb[$];
  rec_t last;
  rec_t mr;

  int n_tests = 0;
  int n_fail = 0;
  int seen_ticks = 0;
  int m_ticks = 0;
  int m_page = 0;
  int m_show = 0;
  bit m_pend = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A whole transition is known the moment it starts.
  // Brightness follows from the tick index: it goes down one level per STEP ticks, and the exit tick lands on SWITCH.
  // After that it rises one level per STEP ticks.
  task automatic start_transition(output rec_t first);
    int np;
    rec_t r;
    np = (m_page + 1) % NP;
    first = '{m_page, 15, 1, 1};
    for (int k = 1; k <= 16 * STEP; k++) begin
      if (k == 16 * STEP) r = '{m_page, 0, 1, 2};
      else r = '{m_page, 15 - k / STEP, 1, 1};
      sched.push_back(r);
    end
    for (int j = 1; j <= 15 * STEP; j++) begin
      if (j == 15 * STEP) r = '{np, 15, 0, 0};
      else r = '{np, j / STEP, 1, 3};
      sched.push_back(r);
    end
    m_page = np;
    m_show = 0;
  endtask

  task automatic model_tick();
    rec_t r;
    m_ticks++;
    if (sched.size() > 0) begin
      r = sched.pop_front();
    end else if (m_pend) begin
      m_pend = 1'b0;
      start_transition(r);
    end else begin
      m_show++;
      if (HOLD != 0 && m_show == HOLD) start_transition(r);
      else r = '{m_page, 15, 0, 0};
    end
    sb.push_back(r);
    last = r;
  endtask

  task automatic model_reset();
    sched.delete();
    m_page = 0;
    m_show = 0;
    m_pend = 1'b0;
  endtask

  // One frame with vs low at its start.
  // A press holds the button for 10 cycles, and a glitch holds it for 3.
  // Optionally reset pulses mid-frame.
  task automatic drive_frame(input bit do_press, input bit do_glitch, input int low_len, input bit do_rst);
    for (int c = 0; c < low_len + 18; c++) begin
      @(negedge clk);
      vs     = (c < low_len) ? 1'b0 : 1'b1;
      button = (do_press && c >= 3 && c < 13) || (do_glitch && c >= 3 && c < 6);
      reset  = do_rst && (c == 5);
      if (do_rst && c == 6) begin
        check("rst_mid_page", int'(page), 0);
        check("rst_mid_bright", int'(brightness), 15);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_tick", int'(frame_tick), 0);
        model_reset();
      end
    end
    if (do_press) m_pend = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        seen_ticks++;
        @(negedge clk);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tick: got a frame_tick, expected none (t=%0t)", $time);
        end else begin
          mr = sb.pop_front();
          check("tick_page", int'(page), mr.page);
          check("tick_bright", int'(brightness), mr.bright);
          check("tick_busy", int'(busy), mr.busy);
        end
      end
    end
  end

  initial begin
    bit found;
    bit p;
    int presses;
    int t0;
    int r;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_page", int'(page), 0);
    check("reset_bright", int'(brightness), 15);
    check("reset_busy", int'(busy), 0);
    check("reset_tick", int'(frame_tick), 0);
    reset = 1'b0;
    model_reset();

    model_tick(); drive_frame(1'b0, 1'b1, 2, 1'b0);
    model_tick(); drive_frame(1'b1, 1'b0, 2, 1'b0);

    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      model_tick();
      p = !found && last.phase == 1 && last.bright == 8;
      if (p) found = 1'b1;
      drive_frame(p, 1'b0, 2, 1'b0);
    end
    check("press_at_bright8_seen", int'(found), 1);

    presses = 0;
    for (int i = 0; i < 110; i++) begin
      model_tick();
      p = (presses < 2) && (last.phase != 0);
      if (p) presses++;
      drive_frame(p, 1'b0, 2, 1'b0);
    end
    check("double_press_issued", presses, 2);

    for (int i = 0; i < 60; i++) begin
      model_tick();
      r = int'($urandom_range(0, 5));
      drive_frame(r == 0, r == 1, 2, 1'b0);
    end

    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      model_tick();
      if (last.phase == 3 && last.bright == 5) begin
        found = 1'b1;
        drive_frame(1'b0, 1'b0, 2, 1'b1);
      end else begin
        drive_frame(last.phase != 0 && !m_pend, 1'b0, 2, 1'b0);
      end
    end
    check("reset_in_fade_in_seen", int'(found), 1);

    for (int i = 0; i < 5; i++) begin
      model_tick();
      drive_frame(1'b0, 1'b0, 2, 1'b0);
    end

    t0 = seen_ticks;
    model_tick();
    drive_frame(1'b0, 1'b0, 100, 1'b0);
    check("long_vs_ticks", seen_ticks - t0, 1);

    for (int i = 0; i < 3; i++) begin
      model_tick();
      drive_frame(1'b0, 1'b0, 2, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("tick_count", seen_ticks, m_ticks);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
